// File: rtl/lbist_pkg.sv
// Shared definitions for the logic-BIST pattern generator / signature compactor.
package lbist_pkg;

  // Run controller states.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } run_state_e;

  // Default register width and the matching feedback polynomial (taps 63,62,13,4,0).
  localparam int          DEFAULT_WIDTH = 65;
  localparam logic [64:0] DEFAULT_TAPS  = 65'h0_C000_0000_0000_2011;
  localparam logic [64:0] DEFAULT_SEED  = 65'h1;

  // Width needed to hold a shift count from 0 up to and including n.
  function automatic int count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/lbist_run_ctrl.sv
// Counted-run controller: decides when the state register may shift and
// tracks how many shifts of the current run have completed.
// shift_ok is a qualifier, not a handshake: a shift happens on a cycle where
// en=1 and shift_ok=1 (load always wins in the parent and is handled there).
module lbist_run_ctrl
  import lbist_pkg::*;
#(
  parameter int N_PATTERNS = 1024,
  parameter int CW         = count_width(N_PATTERNS)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic          load,
  input  logic          start,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] count,
  output logic          shift_ok,
  output run_state_e    fsm_state
);

  run_state_e    state_q, state_d;
  logic [CW-1:0] count_d;
  logic [CW-1:0] count_inc;

  assign count_inc = count + CW'(1);

  // State and counter registers; active-low synchronous reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      count   <= '0;
    end else begin
      state_q <= state_d;
      count   <= count_d;
    end
  end

  // Next state, next count and the shift qualifier.
  always_comb begin
    state_d  = state_q;
    count_d  = count;
    shift_ok = 1'b0;
    if (load) begin
      state_d = ST_IDLE;
      count_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_d = ST_RUN;
            count_d = '0;
          end else begin
            shift_ok = 1'b1;
          end
        end
        ST_RUN: begin
          // start is ignored here; the run only advances on enabled cycles.
          shift_ok = 1'b1;
          if (en) begin
            count_d = count_inc;
            if (count_inc == CW'(N_PATTERNS)) state_d = ST_DONE;
          end
        end
        ST_DONE: begin
          // Signature is frozen until a new run or a load.
          if (start) begin
            state_d = ST_RUN;
            count_d = '0;
          end
        end
        default: begin
          state_d = ST_IDLE;
          count_d = '0;
        end
      endcase
    end
  end

  assign busy      = (state_q == ST_RUN);
  assign done      = (state_q == ST_DONE);
  assign fsm_state = state_q;

endmodule

// File: rtl/lfsr_prpg.sv
// Fibonacci-style LFSR usable as a pseudo-random pattern generator (PRPG)
// or as a multiple-input signature register (MISR), with counted runs.
module lfsr_prpg
  import lbist_pkg::*;
#(
  parameter int               WIDTH      = DEFAULT_WIDTH,
  parameter logic [WIDTH-1:0] TAPS       = WIDTH'(DEFAULT_TAPS),
  parameter logic [WIDTH-1:0] SEED       = WIDTH'(DEFAULT_SEED),
  parameter int               N_PATTERNS = 1024,
  parameter bit               FB_INV     = 1'b0
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic                              en,
  input  logic                              mode_misr,
  input  logic                              load,
  input  logic [WIDTH-1:0]                  seed_in,
  input  logic [WIDTH-1:0]                  data_in,
  input  logic                              start,
  output logic [WIDTH-1:0]                  q,
  output logic                              busy,
  output logic                              done,
  output logic                              zero_lock,
  output logic [$clog2(N_PATTERNS+1)-1:0]   count
);

  localparam int CW = $clog2(N_PATTERNS + 1);

  logic [WIDTH-1:0] state;
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] next_state;
  logic             fb;
  logic             shift_ok;
  run_state_e       run_state;

  lbist_run_ctrl #(
    .N_PATTERNS (N_PATTERNS),
    .CW         (CW)
  ) u_run_ctrl (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .load      (load),
    .start     (start),
    .busy      (busy),
    .done      (done),
    .count     (count),
    .shift_ok  (shift_ok),
    .fsm_state (run_state)
  );

  assign fb        = (^(state & TAPS)) ^ FB_INV;
  assign shifted   = {fb, state[WIDTH-1:1]};
  // The all-zero state is a lock-up only for pattern generation.
  assign zero_lock = (state == '0) && !mode_misr;

  // Next value for an enabled shift: lock-up reload, MISR fold-in, or plain shift.
  always_comb begin
    next_state = shifted;
    if (zero_lock)      next_state = SEED;
    else if (mode_misr) next_state = shifted ^ data_in;
  end

  // State register: reset, then load, then qualified shift, else hold.
  always_ff @(posedge clk) begin
    if (!reset)                state <= SEED;
    else if (load)             state <= seed_in;
    else if (en && shift_ok)   state <= next_state;
  end

  assign q = state;

  // A finished run always reports the full pattern count.
  done_count_a: assert property (@(posedge clk) disable iff (!reset)
    (run_state == ST_DONE) |-> (count == CW'(N_PATTERNS)));

endmodule

// File: tb/tb_lfsr_prpg.sv
// Self-checking bench for lfsr_prpg in a 4-bit, 4-pattern configuration.
module tb_lfsr_prpg;

  localparam int         W    = 4;
  localparam logic [3:0] TAPS = 4'b0011;
  localparam logic [3:0] SEED = 4'b0001;
  localparam int         N    = 4;
  localparam int         CW   = $clog2(N + 1);

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          en = 1'b0;
  logic          mode_misr = 1'b0;
  logic          load = 1'b0;
  logic [W-1:0]  seed_in = '0;
  logic [W-1:0]  data_in = '0;
  logic          start = 1'b0;
  logic [W-1:0]  q;
  logic          busy;
  logic          done;
  logic          zero_lock;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  lfsr_prpg #(
    .WIDTH      (W),
    .TAPS       (TAPS),
    .SEED       (SEED),
    .N_PATTERNS (N),
    .FB_INV     (1'b0)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .en        (en),
    .mode_misr (mode_misr),
    .load      (load),
    .seed_in   (seed_in),
    .data_in   (data_in),
    .start     (start),
    .q         (q),
    .busy      (busy),
    .done      (done),
    .zero_lock (zero_lock),
    .count     (count)
  );

  // ---------------- scoreboard bookkeeping ----------------
  int checks   = 0;
  int failures = 0;
  logic [W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Phase: 0 free-running, 1 counting a run, 2 run finished.
  int           m_phase = 0;
  int           m_count = 0;
  int unsigned  m_state = 0;
  bit           m_valid = 1'b0;

  function automatic int unsigned model_next(input int unsigned s, input logic m, input logic [W-1:0] d);
    int unsigned fb;
    int unsigned nxt;
    if (!m && s == 0) return int'(SEED);
    fb  = $countones(s & int'(TAPS)) % 2;
    nxt = (s / 2) + fb * (1 << (W - 1));
    if (m) nxt = nxt ^ int'(d);
    return nxt;
  endfunction

  always @(posedge clk) begin
    if (!reset) begin
      m_state = int'(SEED); m_phase = 0; m_count = 0; m_valid = 1'b1;
    end else if (load) begin
      m_state = int'(seed_in); m_phase = 0; m_count = 0;
    end else if (start && m_phase != 1) begin
      m_phase = 1; m_count = 0;
    end else if (en && m_phase != 2) begin
      m_state = model_next(m_state, mode_misr, data_in);
      if (m_phase == 1) begin
        m_count++;
        if (m_count == N) m_phase = 2;
      end
    end
  end

  // Compare process: every cycle once the model is meaningful.
  always @(negedge clk) begin
    if (m_valid) begin
      check("cmp_q",         32'(q),         m_state);
      check("cmp_busy",      32'(busy),      32'(m_phase == 1));
      check("cmp_done",      32'(done),      32'(m_phase == 2));
      check("cmp_count",     32'(count),     32'(m_count));
      check("cmp_zero_lock", 32'(zero_lock), 32'(m_state == 0 && !mode_misr));
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic e, input logic m, input logic l,
                       input logic [W-1:0] s, input logic [W-1:0] d, input logic st);
    #1;
    reset = r; en = e; mode_misr = m; load = l; seed_in = s; data_in = d; start = st;
    @(negedge clk);
  endtask

  task automatic do_load(input logic [W-1:0] s);
    drive(1, 0, 0, 1, s, 4'h0, 0);
  endtask

  int n;

  initial begin
    // Reset state.
    drive(0, 1, 0, 1, 4'hA, 4'h0, 1);
    drive(0, 0, 0, 0, 4'h0, 4'h0, 0);
    check("rst_q", 32'(q), 32'h1);
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_count", 32'(count), 0);
    check("rst_zero_lock", 32'(zero_lock), 0);

    // PRPG sequence from 0001.
    exp_q.push_back(4'b1000); exp_q.push_back(4'b0100); exp_q.push_back(4'b0010);
    exp_q.push_back(4'b1001); exp_q.push_back(4'b1100);
    for (int i = 0; i < 5; i++) begin
      drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
      check("prpg_seq", 32'(q), 32'(exp_q.pop_front()));
    end
    for (int i = 0; i < 10; i++) drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    check("prpg_period15", 32'(q), 32'h1);

    // MISR single step.
    do_load(4'b0001);
    drive(1, 1, 1, 0, 4'h0, 4'b0101, 0);
    check("misr_step", 32'(q), 32'b1101);

    // Lock-up in PRPG mode, and no reload in MISR mode.
    do_load(4'b0000);
    check("lock_flag", 32'(zero_lock), 1);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    check("lock_reload", 32'(q), 32'h1);
    check("lock_clear", 32'(zero_lock), 0);
    do_load(4'b0000);
    drive(1, 1, 1, 0, 4'h0, 4'h0, 0);
    check("misr_zero_legal", 32'(q), 32'h0);
    check("misr_no_lock_flag", 32'(zero_lock), 0);

    // Counted run.
    do_load(4'b0001);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 1);
    check("run_start_hold", 32'(q), 32'h1);
    check("run_start_busy", 32'(busy), 1);
    for (int i = 1; i <= 3; i++) begin
      drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
      check("run_busy", 32'(busy), 1);
      check("run_count", 32'(count), 32'(i));
    end
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    check("run_done", 32'(done), 1);
    check("run_busy_off", 32'(busy), 0);
    check("run_count_full", 32'(count), 4);
    check("run_signature", 32'(q), 32'b1001);
    for (int i = 0; i < 3; i++) drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    check("done_hold_q", 32'(q), 32'b1001);
    check("done_hold_flag", 32'(done), 1);

    // start and load together: load wins.
    drive(1, 1, 0, 1, 4'b1010, 4'h0, 1);
    check("coll_load_q", 32'(q), 32'b1010);
    check("coll_load_busy", 32'(busy), 0);

    // start during a run is ignored.
    do_load(4'b0001);
    drive(1, 0, 0, 0, 4'h0, 4'h0, 1);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 1);
    check("coll_start_count", 32'(count), 3);
    check("coll_start_busy", 32'(busy), 1);

    // en=0 gap delays completion by the gap length.
    do_load(4'b0001);
    drive(1, 0, 0, 0, 4'h0, 4'h0, 1);
    n = 0;
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0); n++;
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0); n++;
    for (int i = 0; i < 3; i++) begin drive(1, 0, 0, 0, 4'h0, 4'h0, 0); n++; end
    check("gap_hold_count", 32'(count), 2);
    while (!done && n < 40) begin drive(1, 1, 0, 0, 4'h0, 4'h0, 0); n++; end
    check("gap_done_cycles", 32'(n), 7);

    // Reset mid-run.
    do_load(4'b0110);
    drive(1, 0, 0, 0, 4'h0, 4'h0, 1);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    drive(1, 1, 0, 0, 4'h0, 4'h0, 0);
    check("midrun_count", 32'(count), 2);
    drive(0, 1, 0, 1, 4'hF, 4'h0, 1);
    check("midrun_rst_q", 32'(q), 32'h1);
    check("midrun_rst_busy", 32'(busy), 0);
    check("midrun_rst_done", 32'(done), 0);
    check("midrun_rst_count", 32'(count), 0);

    // Randomized traffic against the model.
    for (int i = 0; i < 400; i++) begin
      drive(logic'($urandom_range(0, 49) != 0),
            logic'($urandom_range(0, 3) != 0),
            logic'($urandom_range(0, 4) == 0),
            logic'($urandom_range(0, 19) == 0),
            ($urandom_range(0, 3) == 0) ? 4'h0 : W'($urandom_range(0, 15)),
            W'($urandom_range(0, 15)),
            logic'($urandom_range(0, 7) == 0));
    end

    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_prpg.md
LFSR_PRPG -- requirements
Module: lfsr_prpg

Interface
REQ-001 SHALL have parameter WIDTH, default 65: state width, legal range 2..128.
REQ-002 SHALL have parameter TAPS, WIDTH bits, default bits 63,62,13,4,0 set: feedback tap mask.
REQ-003 SHALL have parameter SEED, WIDTH bits, default 1: reset and lock-up reload value.
REQ-004 SHALL have parameter N_PATTERNS, default 1024, legal range 1..2^20: shifts per run.
REQ-005 SHALL have parameter FB_INV, default 0: 1 inverts the feedback (XNOR form).
REQ-006 SHALL have port clk, input, 1 bit: the single clock.
REQ-007 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-008 SHALL have port en, input, 1: shift enable.
REQ-009 SHALL have port mode_misr, input, 1: 0 selects PRPG, 1 selects MISR compaction.
REQ-010 SHALL have port load, input, 1: load seed_in into the state.
REQ-011 SHALL have port seed_in, input, WIDTH: runtime seed.
REQ-012 SHALL have port data_in, input, WIDTH: MISR response input.
REQ-013 SHALL have port start, input, 1: begin a counted run.
REQ-014 SHALL have port q, output, WIDTH: current state (pattern or signature).
REQ-015 SHALL have port busy, output, 1: run in progress.
REQ-016 SHALL have port done, output, 1: run complete, signature stable.
REQ-017 SHALL have port zero_lock, output, 1: state is all-zero while in PRPG mode.
REQ-018 SHALL have port count, output, clog2(N_PATTERNS+1) bits: shifts completed in the current run.

Function
REQ-019 SHALL compute fb = XOR-reduce(state AND TAPS) XOR FB_INV.
REQ-020 SHALL compute the PRPG shift as next = {fb, state[WIDTH-1:1]}.
REQ-021 SHALL compute the MISR shift as next = {fb, state[WIDTH-1:1]} XOR data_in.
REQ-022 SHALL, per cycle, apply the first true condition in this order: load, then start, then (en and state change allowed), then hold.
REQ-023 SHALL run an FSM with states IDLE, RUN and DONE.
REQ-024 SHALL, in IDLE, shift whenever en=1 (free-running) and leave count unchanged.
REQ-025 SHALL, on start in IDLE or DONE, enter RUN next cycle, clear count and done, and leave the state unchanged.
REQ-026 SHALL ignore start while in RUN.
REQ-027 SHALL, in RUN, shift and increment count on each cycle with en=1, and hold on each cycle with en=0.
REQ-028 SHALL, in RUN, on the shift that makes count equal N_PATTERNS, enter DONE next cycle with done=1 and busy=0.
REQ-029 SHALL, in DONE, hold the state irrespective of en, so that q holds the signature.
REQ-030 SHALL, on load in any FSM state, set state=seed_in, enter IDLE and clear count, done and busy.
REQ-031 SHALL assert zero_lock combinationally when state==0 and mode_misr=0.
REQ-032 SHALL, on an enabled shift while zero_lock=1, replace the next state with SEED and still increment count in RUN.
REQ-033 SHALL never apply lock-up reload in MISR mode, because an all-zero signature is legal.
REQ-034 SHALL drive busy=1 exactly while the FSM is in RUN.
REQ-035 SHALL take effect on the next shift when mode_misr changes mid-run, with no state flush.

Reset
REQ-036 SHALL, when reset=0 at a clk edge, set state=SEED, FSM=IDLE and count=0.
REQ-037 SHALL, when reset=0 at a clk edge, set done=0 and busy=0, giving q=SEED and zero_lock=0 for any SEED other than 0.
REQ-038 SHALL give reset priority over load, start and en, including mid-run.

Structure
REQ-039 SHALL keep the FSM state enum and the default TAPS/SEED constants in shared package lbist_pkg.
REQ-040 SHALL implement the counter/FSM as a single sub-module, lbist_run_ctrl (outputs: busy, done, count, shift_ok); the lfsr_prpg top holds the state register and feedback logic.

Verification
REQ-041 SHALL cover PRPG sequence (WIDTH=4, TAPS=4'b0011, SEED=4'b0001, en=1, mode 0) -> q = 0001,1000,0100,0010,1001,1100, and q returns to 0001 after 15 shifts.
REQ-042 SHALL cover MISR step (same configuration, state 0001, mode_misr=1, data_in=0101, one shift) -> q=1101.
REQ-043 SHALL cover lock-up (load seed_in=0000, mode 0) -> zero_lock=1; next en cycle -> q=0001 and zero_lock=0; same stimulus in mode 1 -> q remains 0000.
REQ-044 SHALL cover counted run (N_PATTERNS=4, start then en=1 continuously) -> busy=1 for 4 shifts, then done=1, count=4, q=1001 held with en still 1.
REQ-045 SHALL cover collisions: start with load in the same cycle -> q=seed_in and FSM=IDLE; start during RUN -> count unaffected; en=0 gap mid-run -> done delayed by the gap length.
REQ-046 SHALL cover reset=0 asserted mid-RUN at count=2 -> next cycle q=SEED, busy=0, done=0, count=0.
